// File: rtl/apb_reg_bank.sv
// APB-style slave register bank: byte-lane strobes, fixed wait-state insertion,
// per-register write protection and an error response for bad accesses.
module apb_reg_bank #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 16,
  parameter int                    ADDR_WIDTH  = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DEPTH-1:0]      RO_MASK     = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    wr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic                    sel,
  input  logic                    enable,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    slverr
);

  localparam int                  NUM_LANES = DATA_WIDTH / 8;
  localparam logic [3:0]          WAIT_LAST = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("apb_reg_bank: DATA_WIDTH must be a multiple of 8");
  end
  if ((2 ** ADDR_WIDTH) < DEPTH) begin : g_bad_addr_width
    $error("apb_reg_bank: ADDR_WIDTH too narrow for DEPTH");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("apb_reg_bank: WAIT_STATES must be 0..15");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                  state;
  logic [3:0]              wcnt;
  logic [DATA_WIDTH-1:0]   regs [DEPTH];

  logic                    in_range;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    err;
  logic                    do_write;

  // Out-of-range addresses are steered to index 0 so the array and mask are
  // never indexed past DEPTH; err already blocks any effect of that access.
  assign in_range = ({1'b0, addr} < DEPTH_EXT);
  assign idx      = in_range ? addr : '0;
  assign err      = !in_range || (wr && RO_MASK[idx]);

  assign ready    = (state == ACCESS) && sel && enable && (wcnt == WAIT_LAST);
  assign slverr   = ready && err;
  assign rdata    = (ready && !wr && !err) ? regs[idx] : '0;
  assign do_write = ready && wr && !err;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel) begin
            state <= ACCESS;
            wcnt  <= '0;
          end
        end
        ACCESS: begin
          if (!sel) begin
            state <= IDLE;
          end else if (enable) begin
            if (wcnt == WAIT_LAST) state <= IDLE;
            else                   wcnt  <= wcnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the register array is reset like ordinary flops (it is a small
  // register file, not a RAM macro), so RESET_VAL appears without clocking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
    end else if (do_write) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (strb[k]) regs[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank: a default instance and a 12-deep,
// 3-wait-state instance with register 2 read-only, checked via a scoreboard.
module tb_apb_reg_bank;

  localparam logic [31:0] RV1 = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  addr = '0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  strb = '0;
  logic        sel0 = 1'b0, sel1 = 1'b0, enable = 1'b0;
  logic        ready0, ready1, slverr0, slverr1;
  logic [31:0] rdata0, rdata1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  apb_reg_bank dut0 (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wr(wr), .wdata(wdata),
    .strb(strb), .sel(sel0), .enable(enable),
    .ready(ready0), .rdata(rdata0), .slverr(slverr0)
  );

  apb_reg_bank #(
    .DATA_WIDTH(32), .DEPTH(12), .RESET_VAL(RV1),
    .WAIT_STATES(3), .RO_MASK(12'h004)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wr(wr), .wdata(wdata),
    .strb(strb), .sel(sel1), .enable(enable),
    .ready(ready1), .rdata(rdata1), .slverr(slverr1)
  );

  function automatic logic get_ready(bit which);
    return which ? ready1 : ready0;
  endfunction
  function automatic logic get_err(bit which);
    return which ? slverr1 : slverr0;
  endfunction
  function automatic logic [31:0] get_rdata(bit which);
    return which ? rdata1 : rdata0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transfer. 'early' is driven on wdata until the completing cycle;
  // 'viol' raises enable already in the setup cycle.
  task automatic xfer(input bit which, input logic [3:0] a, input logic w,
                      input logic [31:0] d, input logic [31:0] early,
                      input logic [3:0] s, input logic [31:0] exp_rdata,
                      input logic exp_err, input int exp_waits,
                      input bit viol, input string tag);
    int   n;
    bit   done;
    exp_t e;
    @(negedge clk);
    sb.push_back('{tag, exp_rdata, exp_err, exp_waits});
    addr = a; wr = w; wdata = early; strb = s; enable = viol;
    if (which) sel1 = 1'b1; else sel0 = 1'b1;
    #1 chk({tag, "/setup_ready"}, 32'(get_ready(which)), 32'd0);
    n = 0;
    done = 1'b0;
    while (!done && n <= 20) begin
      @(negedge clk);
      enable = 1'b1;
      wdata  = (n == exp_waits) ? d : early;
      #1;
      if (get_ready(which)) done = 1'b1;
      else n++;
    end
    e = sb.pop_front();
    if (!done) begin
      chk({e.tag, "/completed"}, 32'(done), 32'd1);
    end else begin
      chk({e.tag, "/waits"},  32'(n), 32'(e.waits));
      chk({e.tag, "/slverr"}, 32'(get_err(which)), 32'(e.err));
      chk({e.tag, "/rdata"},  get_rdata(which), e.rdata);
    end
    @(negedge clk);
    sel0 = 1'b0; sel1 = 1'b0; enable = 1'b0;
  endtask

  task automatic wr_op(input bit which, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic exp_err, input string tag);
    xfer(which, a, 1'b1, d, d, s, 32'd0, exp_err, which ? 3 : 0, 1'b0, tag);
  endtask

  task automatic rd_op(input bit which, input logic [3:0] a, input logic [31:0] exp,
                       input logic exp_err, input string tag);
    xfer(which, a, 1'b0, 32'd0, 32'd0, 4'h0, exp, exp_err, which ? 3 : 0, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset_n = 1'b0;
    #2;
    chk("rst/ready0",  32'(ready0),  32'd0);
    chk("rst/slverr0", 32'(slverr0), 32'd0);
    chk("rst/rdata0",  rdata0,       32'd0);
    chk("rst/rdata1",  rdata1,       32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) rd_op(1'b0, 4'(i), 32'd0, 1'b0, $sformatf("rst_rd0_%0d", i));
    for (int i = 0; i < 12; i++) rd_op(1'b1, 4'(i), RV1,   1'b0, $sformatf("rst_rd1_%0d", i));

    // Full-word write and byte-lane merge on the zero-wait instance.
    wr_op(1'b0, 4'd3, 32'hDEAD_BEEF, 4'hF, 1'b0, "w3");
    rd_op(1'b0, 4'd3, 32'hDEAD_BEEF, 1'b0, "r3");
    wr_op(1'b0, 4'd5, 32'h1122_3344, 4'hF, 1'b0, "w5_full");
    wr_op(1'b0, 4'd5, 32'hAABB_CCDD, 4'b0101, 1'b0, "w5_strb");
    rd_op(1'b0, 4'd5, 32'h11BB_33DD, 1'b0, "r5_strb");
    wr_op(1'b0, 4'd5, 32'hFFFF_FFFF, 4'h0, 1'b0, "w5_nostrb");
    rd_op(1'b0, 4'd5, 32'h11BB_33DD, 1'b0, "r5_nostrb");
    wr_op(1'b0, 4'd15, 32'h0F0F_F0F0, 4'hF, 1'b0, "w15");
    rd_op(1'b0, 4'd15, 32'h0F0F_F0F0, 1'b0, "r15");

    // Enable already high in the setup cycle: still one setup, then ACCESS.
    xfer(1'b0, 4'd3, 1'b0, 32'd0, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b1, "viol_rd3");

    // Wait states with wdata changing until the completing cycle.
    xfer(1'b1, 4'd5, 1'b1, 32'h1234_5678, 32'hFFFF_0000, 4'hF, 32'd0, 1'b0, 3, 1'b0, "w1_5_wait");
    rd_op(1'b1, 4'd5, 32'h1234_5678, 1'b0, "r1_5");

    // Error responses.
    wr_op(1'b1, 4'd13, 32'h5555_AAAA, 4'hF, 1'b1, "w1_13_oor");
    rd_op(1'b1, 4'd5, 32'h1234_5678, 1'b0, "r1_5_after_oor");
    rd_op(1'b1, 4'd1, RV1, 1'b0, "r1_1_after_oor");
    wr_op(1'b1, 4'd2, 32'h0000_0000, 4'hF, 1'b1, "w1_2_ro");
    rd_op(1'b1, 4'd2, RV1, 1'b0, "r1_2_ro");
    rd_op(1'b1, 4'd14, 32'd0, 1'b1, "r1_14_oor");
    rd_op(1'b1, 4'd12, 32'd0, 1'b1, "r1_12_oor");
    rd_op(1'b1, 4'd11, RV1, 1'b0, "r1_11");

    // Abort: sel dropped during a wait state.
    @(negedge clk);
    addr = 4'd7; wr = 1'b1; wdata = 32'h0BAD_F00D; strb = 4'hF; sel1 = 1'b1; enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    #1 chk("abort/ready_w0", 32'(ready1), 32'd0);
    @(negedge clk);
    #1 chk("abort/ready_w1", 32'(ready1), 32'd0);
    @(negedge clk);
    sel1 = 1'b0; enable = 1'b0;
    #1 chk("abort/ready_drop", 32'(ready1), 32'd0);
    rd_op(1'b1, 4'd7, RV1, 1'b0, "abort_r7");

    // Reset while the zero-wait instance is presenting read data.
    @(negedge clk);
    addr = 4'd3; wr = 1'b0; sel0 = 1'b1; enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    #1 chk("rstmid/pre_rdata", rdata0, 32'hDEAD_BEEF);
    #1 reset_n = 1'b0;
    #1;
    chk("rstmid/ready0",  32'(ready0),  32'd0);
    chk("rstmid/slverr0", 32'(slverr0), 32'd0);
    chk("rstmid/rdata0",  rdata0,       32'd0);
    sel0 = 1'b0; enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd_op(1'b0, 4'd3, 32'd0, 1'b0, "rstmid_r3");
    rd_op(1'b0, 4'd5, 32'd0, 1'b0, "rstmid_r5");

    // Reset during a wait state of a write on the 3-wait instance.
    @(negedge clk);
    addr = 4'd4; wr = 1'b1; wdata = 32'h7777_7777; strb = 4'hF; sel1 = 1'b1; enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("rstwait/ready1", 32'(ready1), 32'd0);
    @(negedge clk);
    sel1 = 1'b0; enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd_op(1'b1, 4'd4, RV1, 1'b0, "rstwait_r4");
    rd_op(1'b1, 4'd5, RV1, 1'b0, "rstwait_r5");
    wr_op(1'b1, 4'd4, 32'hA5A5_5A5A, 4'hF, 1'b0, "rstwait_w4");
    rd_op(1'b1, 4'd4, 32'hA5A5_5A5A, 1'b0, "rstwait_r4b");

    chk("sb/empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
